keccak_squeeze: RTL and testbench

- Output/squeeze stage for the SHA-3 family; sits between f_permutation and the user.
- Latches the 1600-bit permutation state and applies the in-lane byte reorder.
- Streams the digest as OUT_W-bit words over a valid/ready handshake.
- For SHAKE modes, it requests further permutations (squeeze blocks) until the requested byte length has been delivered.

---
 rtl/keccak_squeeze.sv | 167 ++++++++++++++++
 tb/tb_keccak_squeeze.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keccak_squeeze.sv
// SHA-3 / SHAKE squeeze stage: latches the permutation state and streams the digest as
// OUT_W-bit words. Define KECCAK_SQZ_ERR_EN to enable the sticky err flag (tied to 0 otherwise).
module keccak_squeeze #(
    parameter int OUT_W = 64,
    parameter int LEN_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         mode,
    input  logic [LEN_W-1:0]   out_len,
    input  logic [1599:0]      state_in,
    input  logic               state_valid,
    output logic               perm_req,
    output logic [1599:0]      perm_state_out,
    output logic [OUT_W-1:0]   dout,
    output logic [OUT_W/8-1:0] dout_keep,
    output logic               dout_valid,
    input  logic               dout_ready,
    output logic               dout_last,
    output logic               done,
    output logic               busy,
    output logic               err
);
    localparam int BPW = OUT_W / 8;

    typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, PERM_WAIT = 2'd2} fsm_t;

    fsm_t             fsm_q, fsm_d;
    logic [1599:0]    state_q, state_d;
    logic [2:0]       mode_q, mode_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [7:0]       ptr_q, ptr_d;
    logic             done_q, done_d;
    logic             perm_req_q, perm_req_d;
    logic             err_q, err_d;

    function automatic logic [7:0] rate_of(input logic [2:0] m);
        case (m)
            3'd0:       rate_of = 8'd72;
            3'd1:       rate_of = 8'd104;
            3'd2, 3'd5: rate_of = 8'd136;
            3'd3:       rate_of = 8'd144;
            default:    rate_of = 8'd168;
        endcase
    endfunction

    function automatic logic [LEN_W-1:0] start_len(input logic [2:0] m, input logic [LEN_W-1:0] len);
        case (m)
            3'd0:    start_len = LEN_W'(64);
            3'd1:    start_len = LEN_W'(48);
            3'd2:    start_len = LEN_W'(32);
            3'd3:    start_len = LEN_W'(28);
            default: start_len = len;
        endcase
    endfunction

    // Only the tail word can be partial; byte j is kept while j < remaining.
    function automatic logic [BPW-1:0] keep_of(input logic [LEN_W-1:0] r);
        for (int j = 0; j < BPW; j++) keep_of[j] = (r > LEN_W'(j));
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q      <= IDLE;
            state_q    <= '0;
            mode_q     <= '0;
            rem_q      <= '0;
            ptr_q      <= '0;
            done_q     <= 1'b0;
            perm_req_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            fsm_q      <= fsm_d;
            state_q    <= state_d;
            mode_q     <= mode_d;
            rem_q      <= rem_d;
            ptr_q      <= ptr_d;
            done_q     <= done_d;
            perm_req_q <= perm_req_d;
            err_q      <= err_d;
        end
    end

    logic             accept, word_last, block_end, is_shake, mode_ok;
    logic [LEN_W-1:0] rem_next;
    logic [7:0]       ptr_next;

    always_comb begin
        fsm_d      = fsm_q;
        state_d    = state_q;
        mode_d     = mode_q;
        rem_d      = rem_q;
        ptr_d      = ptr_q;
        done_d     = 1'b0;
        perm_req_d = 1'b0;
        err_d      = err_q;
        accept     = (fsm_q == STREAM) && dout_ready;
        word_last  = (rem_q <= LEN_W'(BPW));
        rem_next   = word_last ? '0 : rem_q - LEN_W'(BPW);
        ptr_next   = ptr_q + 8'(BPW);
        block_end  = (ptr_next == rate_of(mode_q));
        is_shake   = (mode == 3'd4) || (mode == 3'd5);
        mode_ok    = (mode <= 3'd5);
        case (fsm_q)
            IDLE: begin
                if (state_valid && mode_ok) begin
                    state_d = state_in;
                    mode_d  = mode;
                    rem_d   = start_len(mode, out_len);
                    ptr_d   = '0;
                    if (is_shake && out_len == '0) done_d = 1'b1;
                    else                           fsm_d  = STREAM;
                end
            end
            STREAM: begin
                if (accept) begin
                    rem_d = rem_next;
                    ptr_d = ptr_next;
                    // The final word wins over a coincident block boundary.
                    if (word_last) begin
                        done_d = 1'b1;
                        fsm_d  = IDLE;
                    end else if (block_end) begin
                        perm_req_d = 1'b1;
                        fsm_d      = PERM_WAIT;
                    end
                end
            end
            PERM_WAIT: begin
                if (state_valid) begin
                    state_d = state_in;
                    ptr_d   = '0;
                    fsm_d   = STREAM;
                end
            end
            default: fsm_d = IDLE;
        endcase
`ifdef KECCAK_SQZ_ERR_EN
        if (state_valid && fsm_q == STREAM) err_d = 1'b1;
        if (state_valid && fsm_q == IDLE && !mode_ok) err_d = 1'b1;
        if (state_valid && fsm_q == IDLE && is_shake && (out_len > ({LEN_W{1'b1}} - rem_q))) err_d = 1'b1;
`endif
    end

    // Lane w occupies [1599-64w -: 64]; bytes inside a lane are little-endian.
    logic [10:0] word_base;

    always_comb begin
        dout_valid = (fsm_q == STREAM);
        busy       = (fsm_q != IDLE);
        word_base  = 11'd1536 - {ptr_q[7:3], 6'b0} + 11'({ptr_q[2:0], 3'b0});
        dout       = '0;
        dout_keep  = '0;
        dout_last  = 1'b0;
        if (dout_valid) begin
            dout      = state_q[word_base +: OUT_W];
            dout_keep = keep_of(rem_q);
            dout_last = (rem_q <= LEN_W'(BPW));
        end
    end

    assign perm_req       = perm_req_q;
    assign perm_state_out = state_q;
    assign done           = done_q;
    assign err            = err_q;

endmodule

// File: tb/tb_keccak_squeeze.sv
// Bench for keccak_squeeze: a 64-bit and a 32-bit instance share stimulus; sel32 picks the one observed.
module tb_keccak_squeeze;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, state_valid, rdy, sel32;
    logic [2:0]    mode;
    logic [15:0]   out_len;
    logic [1599:0] state_in;

    logic          perm_req64, v64, last64, done64, busy64, err64;
    logic [1599:0] pso64;
    logic [63:0]   dout64;
    logic [7:0]    keep64;
    logic          perm_req32, v32, last32, done32, busy32, err32;
    logic [1599:0] pso32;
    logic [31:0]   dout32;
    logic [3:0]    keep32;

    keccak_squeeze #(.OUT_W(64), .LEN_W(16)) dut64 (
        .clk(clk), .reset(reset), .mode(mode), .out_len(out_len), .state_in(state_in),
        .state_valid(state_valid), .perm_req(perm_req64), .perm_state_out(pso64),
        .dout(dout64), .dout_keep(keep64), .dout_valid(v64), .dout_ready(rdy),
        .dout_last(last64), .done(done64), .busy(busy64), .err(err64)
    );

    keccak_squeeze #(.OUT_W(32), .LEN_W(16)) dut32 (
        .clk(clk), .reset(reset), .mode(mode), .out_len(out_len), .state_in(state_in),
        .state_valid(state_valid), .perm_req(perm_req32), .perm_state_out(pso32),
        .dout(dout32), .dout_keep(keep32), .dout_valid(v32), .dout_ready(rdy),
        .dout_last(last32), .done(done32), .busy(busy32), .err(err32)
    );

    logic          c_valid, c_last, c_done, c_busy, c_err, c_perm_req;
    logic [63:0]   c_dout;
    logic [7:0]    c_keep;
    logic [1599:0] c_pso;

    always_comb begin
        if (sel32) begin
            c_valid = v32; c_last = last32; c_done = done32; c_busy = busy32; c_err = err32;
            c_perm_req = perm_req32; c_dout = {32'b0, dout32}; c_keep = {4'b0, keep32}; c_pso = pso32;
        end else begin
            c_valid = v64; c_last = last64; c_done = done64; c_busy = busy64; c_err = err64;
            c_perm_req = perm_req64; c_dout = dout64; c_keep = keep64; c_pso = pso64;
        end
    end

`ifdef KECCAK_SQZ_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } word_t;

    typedef struct {
        logic        sel;
        logic [2:0]  mode;
        logic [15:0] len;
        int          n_words;
        logic [7:0]  last_keep;
        int          n_perm;
    } vec_t;

    word_t         sb[$];
    int            n_pass = 0, n_total = 0;
    int            words, perms, dones, rem_m, bpw_m, rate_m;
    logic [7:0]    last_keep_seen;
    logic [1599:0] last_state;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [7:0] byte_of(input logic [1599:0] s, input int k);
        int base;
        base = 1536 - 64 * (k / 8) + 8 * (k % 8);
        return s[base +: 8];
    endfunction

    function automatic int rate_b(input logic [2:0] m);
        case (m)
            3'd0: return 72;
            3'd1: return 104;
            3'd2: return 136;
            3'd3: return 144;
            3'd4: return 168;
            default: return 136;
        endcase
    endfunction

    function automatic int len_b(input logic [2:0] m, input int l);
        case (m)
            3'd0: return 64;
            3'd1: return 48;
            3'd2: return 32;
            3'd3: return 28;
            default: return l;
        endcase
    endfunction

    function automatic logic [1599:0] rand_state();
        logic [1599:0] s;
        for (int i = 0; i < 50; i++) s[32*i +: 32] = $urandom;
        return s;
    endfunction

    task automatic push_block(input logic [1599:0] s, input int bpw, input int rate, inout int rem);
        int    k;
        word_t w;
        k = 0;
        while (k < rate && rem > 0) begin
            w.data = '0;
            w.keep = '0;
            for (int j = 0; j < bpw; j++) begin
                w.data[8*j +: 8] = byte_of(s, k + j);
                w.keep[j]        = (j < rem);
            end
            w.last = (rem <= bpw);
            sb.push_back(w);
            rem = (rem > bpw) ? rem - bpw : 0;
            k += bpw;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        state_valid = 1'b0;
        rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        sb.delete();
    endtask

    task automatic check_accept();
        word_t w;
        if (c_valid && rdy) begin
            chk("sb_has_word", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                w = sb.pop_front();
                chk("dout", c_dout, w.data);
                chk("keep", 64'(c_keep), 64'(w.keep));
                chk("last", 64'(c_last), 64'(w.last));
            end
            words++;
            if (c_last) last_keep_seen = c_keep;
        end
    endtask

    // Called at posedge+1; runs until done (plus a short tail) or the cycle budget expires.
    task automatic run_stream(input bit rnd, input int budget);
        int            cyc, tail, feed;
        logic          stall;
        logic [63:0]   hd;
        logic [7:0]    hk;
        logic          hl;
        logic [1599:0] s;
        cyc = 0; tail = -1; feed = 0; stall = 1'b0; hd = '0; hk = '0; hl = 1'b0;
        words = 0; perms = 0; dones = 0; last_keep_seen = '0;
        while (cyc < budget && tail != 0) begin
            @(negedge clk);
            if (c_valid) begin
                if (stall) begin
                    chk("hold_dout", c_dout, hd);
                    chk("hold_keep", 64'(c_keep), 64'(hk));
                    chk("hold_last", 64'(c_last), 64'(hl));
                end
                check_accept();
                stall = !rdy;
                hd = c_dout; hk = c_keep; hl = c_last;
            end else begin
                stall = 1'b0;
            end
            if (c_perm_req) begin
                perms++;
                chk("perm_state_out", 64'(c_pso == last_state), 64'd1);
                feed = 3;
            end
            if (c_done) begin
                dones++;
                if (tail < 0) tail = 3;
            end
            @(posedge clk);
            #1;
            state_valid = 1'b0;
            if (feed > 0) begin
                feed--;
                if (feed == 0) begin
                    s = rand_state();
                    push_block(s, bpw_m, rate_m, rem_m);
                    state_in = s;
                    state_valid = 1'b1;
                    last_state = s;
                end
            end
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (tail > 0) tail--;
            cyc++;
        end
        chk("finished_in_budget", 64'(tail == 0), 64'd1);
    endtask

    task automatic start_case(input vec_t v);
        logic [1599:0] s;
        sel32 = v.sel;
        mode = v.mode;
        out_len = v.len;
        bpw_m = v.sel ? 4 : 8;
        rate_m = rate_b(v.mode);
        rem_m = len_b(v.mode, int'(v.len));
        s = rand_state();
        push_block(s, bpw_m, rate_m, rem_m);
        state_in = s;
        state_valid = 1'b1;
        last_state = s;
    endtask

    task automatic finish_case(input vec_t v, input bit rnd);
        run_stream(rnd, 600);
        chk("word_count", 64'(words), 64'(v.n_words));
        chk("final_keep", 64'(last_keep_seen), 64'(v.last_keep));
        chk("perm_count", 64'(perms), 64'(v.n_perm));
        chk("done_count", 64'(dones), 64'd1);
        chk("sb_drained", 64'(sb.size()), 64'd0);
    endtask

    vec_t          vt[12];
    vec_t          v;
    logic [1599:0] s2;

    initial begin
        vt[0]  = '{1'b1, 3'd2, 16'd0,   8,  8'h0F, 0};
        vt[1]  = '{1'b0, 3'd3, 16'd0,   4,  8'h0F, 0};
        vt[2]  = '{1'b0, 3'd4, 16'd200, 25, 8'hFF, 1};
        vt[3]  = '{1'b0, 3'd0, 16'd0,   8,  8'hFF, 0};
        vt[4]  = '{1'b0, 3'd1, 16'd0,   6,  8'hFF, 0};
        vt[5]  = '{1'b0, 3'd2, 16'd0,   4,  8'hFF, 0};
        vt[6]  = '{1'b0, 3'd5, 16'd20,  3,  8'h0F, 0};
        vt[7]  = '{1'b0, 3'd4, 16'd0,   0,  8'h00, 0};
        vt[8]  = '{1'b0, 3'd5, 16'd136, 17, 8'hFF, 0};
        vt[9]  = '{1'b0, 3'd5, 16'd137, 18, 8'h01, 1};
        vt[10] = '{1'b1, 3'd3, 16'd0,   7,  8'h0F, 0};
        vt[11] = '{1'b1, 3'd5, 16'd6,   2,  8'h03, 0};

        sel32 = 1'b0; mode = 3'd0; out_len = '0; state_in = '0; state_valid = 1'b0; rdy = 1'b1;
        last_state = '0;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_valid", 64'(c_valid), 64'd0);
        chk("rst_dout", c_dout, 64'd0);
        chk("rst_keep", 64'(c_keep), 64'd0);
        chk("rst_last", 64'(c_last), 64'd0);
        chk("rst_done", 64'(c_done), 64'd0);
        chk("rst_busy", 64'(c_busy), 64'd0);
        chk("rst_perm_req", 64'(c_perm_req), 64'd0);
        chk("rst_err", 64'(c_err), 64'd0);
        chk("rst_perm_state", 64'(c_pso == '0), 64'd1);

        for (int i = 0; i < 12; i++) begin
            do_reset();
            start_case(vt[i]);
            finish_case(vt[i], 1'b0);
        end

        // Latency of one cycle, then SHA3-512 under random backpressure.
        do_reset();
        v = '{1'b0, 3'd0, 16'd0, 8, 8'hFF, 0};
        rdy = 1'b0;
        start_case(v);
        @(negedge clk);
        chk("latency_pre", 64'(c_valid), 64'd0);
        @(posedge clk);
        #1 state_valid = 1'b0;
        @(negedge clk);
        chk("latency_post", 64'(c_valid), 64'd1);
        @(posedge clk);
        #1;
        finish_case(v, 1'b1);

        // Reset in the middle of a SHAKE256 stream, then a clean restart from byte 0.
        do_reset();
        v = '{1'b0, 3'd5, 16'd100, 13, 8'h0F, 0};
        start_case(v);
        words = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_accept();
            @(posedge clk);
            #1 state_valid = 1'b0;
        end
        chk("mid_words", 64'(words), 64'd3);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(c_valid), 64'd0);
        chk("mid_rst_dout", c_dout, 64'd0);
        chk("mid_rst_last", 64'(c_last), 64'd0);
        chk("mid_rst_busy", 64'(c_busy), 64'd0);
        chk("mid_rst_perm_state", 64'(c_pso == '0), 64'd1);
        @(posedge clk);
        #1 reset = 1'b0;
        sb.delete();
        start_case(v);
        finish_case(v, 1'b0);

        // state_valid while streaming must not disturb the digest.
        do_reset();
        v = '{1'b0, 3'd2, 16'd0, 4, 8'hFF, 0};
        rdy = 1'b0;
        start_case(v);
        repeat (3) begin
            @(posedge clk);
            #1 state_valid = 1'b0;
        end
        s2 = rand_state();
        state_in = s2;
        mode = 3'd4;
        out_len = 16'd300;
        state_valid = 1'b1;
        @(posedge clk);
        #1 state_valid = 1'b0;
        @(negedge clk);
        chk("err_stream_sv", 64'(c_err), 64'(ERR_EXP));
        @(posedge clk);
        #1 rdy = 1'b1;
        finish_case(v, 1'b0);
        chk("err_sticky", 64'(c_err), 64'(ERR_EXP));

        // Reserved mode is ignored.
        do_reset();
        sel32 = 1'b0;
        mode = 3'd6;
        state_in = rand_state();
        state_valid = 1'b1;
        @(posedge clk);
        #1 state_valid = 1'b0;
        @(negedge clk);
        chk("rsv_busy", 64'(c_busy), 64'd0);
        chk("rsv_valid", 64'(c_valid), 64'd0);
        chk("rsv_err", 64'(c_err), 64'(ERR_EXP));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got %0d/%0d checks", n_pass, n_total);
        $fatal(1);
    end
endmodule
